// File: rtl/systolic_pe_acc.sv
// ---------------------------------------------------------------------------
// systolic_pe_acc
//
// Output-stationary multiply-accumulate cell for a systolic matrix-multiply
// array. Operands A (from the west) and B (from the north) are forwarded
// east and south with one cycle of latency. Whenever both operands are valid,
// A*B is added into a wide accumulator. The finished tile result is shifted
// out through a per-column drain chain that runs from north to south on
// c_in/c_out.
//
// Parameters:
//   DATA_W  operand width
//   ACC_W   accumulator / drain width (must be >= 2*DATA_W)
//   SIGNED  1 = two's-complement arithmetic, 0 = unsigned
//   CNT_W   MAC counter width
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   a_in, a_vld_in        operand from west neighbour and its valid
//   b_in, b_vld_in        operand from north neighbour and its valid
//   clr                   start a new tile; this cycle's product seeds it
//   drain                 request result drain (held high to stay in PASS)
//   c_in, c_vld_in        drain data from north neighbour and its valid
//   a_out, a_vld_out      registered A and its valid to east
//   b_out, b_vld_out      registered B and its valid to south
//   c_out, c_vld_out      drain data and its valid to south
//   mac_cnt               saturating count of MACs in the current tile
//   busy                  high while in LOAD or PASS
//   ovf                   sticky accumulator overflow for the current tile
//
// Build option:
//   SYSTOLIC_PE_SAT_EN    when defined, an overflowing accumulation clamps to
//                         the representable max/min instead of wrapping.
// ---------------------------------------------------------------------------
module systolic_pe_acc #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int SIGNED = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    input  logic              clr,
    input  logic              drain,
    input  logic [ACC_W-1:0]  c_in,
    input  logic              c_vld_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    output logic [ACC_W-1:0]  c_out,
    output logic              c_vld_out,
    output logic [CNT_W-1:0]  mac_cnt,
    output logic              busy,
    output logic              ovf
);

    if (ACC_W < 2 * DATA_W) begin : g_width_check
        $error("systolic_pe_acc: ACC_W must be at least 2*DATA_W");
    end

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_LOAD = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;

    logic               mac_fire;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W:0]     sum_chk;
    logic [ACC_W-1:0]   acc_next;
    logic               ovf_next;
    logic [CNT_W-1:0]   cnt_next;

    // Clamp value used when an accumulation overflows: toward the direction
    // the sum was heading (max for positive overflow, min for negative).
    function automatic logic [ACC_W-1:0] sat_limit(input logic neg);
        logic [ACC_W-1:0] lim;
        if (SIGNED != 0) begin
            lim = neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            lim = {ACC_W{1'b1}};
        end
        return lim;
    endfunction

    // Returns {overflow, result}. Signed overflow: both addends share a sign
    // that the sum does not. Unsigned overflow: carry out of the MSB.
    function automatic logic [ACC_W:0] add_chk(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y);
        logic [ACC_W:0]   s;
        logic             o;
        logic [ACC_W-1:0] r;
        s = {1'b0, x} + {1'b0, y};
        if (SIGNED != 0) begin
            o = (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
        end else begin
            o = s[ACC_W];
        end
        r = s[ACC_W-1:0];
`ifdef SYSTOLIC_PE_SAT_EN
        if (o) begin
            r = sat_limit(x[ACC_W-1]);
        end
`else
        if (o && 1'b0) begin
            r = sat_limit(x[ACC_W-1]);
        end
`endif
        return {o, r};
    endfunction

    // Stage 0: product formation and accumulate candidate (combinational)
    always_comb begin
        mac_fire = a_vld_in & b_vld_in;
        if (SIGNED != 0) begin
            a_ext = {{DATA_W{a_in[DATA_W-1]}}, a_in};
            b_ext = {{DATA_W{b_in[DATA_W-1]}}, b_in};
        end else begin
            a_ext = {{DATA_W{1'b0}}, a_in};
            b_ext = {{DATA_W{1'b0}}, b_in};
        end
        // Low 2*DATA_W bits of the extended product are exact in both modes.
        prod = a_ext * b_ext;

        prod_ext = '0;
        prod_ext[2*DATA_W-1:0] = prod;
        for (int i = 2 * DATA_W; i < ACC_W; i++) begin
            prod_ext[i] = (SIGNED != 0) ? prod[2*DATA_W-1] : 1'b0;
        end

        sum_chk = add_chk(acc, prod_ext);

        acc_next = acc;
        ovf_next = ovf;
        cnt_next = mac_cnt;
        if (clr) begin
            acc_next = mac_fire ? prod_ext : '0;
            ovf_next = 1'b0;
            cnt_next = CNT_W'(mac_fire);
        end else if (mac_fire) begin
            acc_next = sum_chk[ACC_W-1:0];
            ovf_next = ovf | sum_chk[ACC_W];
            if (mac_cnt != {CNT_W{1'b1}}) begin
                cnt_next = mac_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1: operand forwarding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out     <= '0;
            a_vld_out <= 1'b0;
            b_out     <= '0;
            b_vld_out <= 1'b0;
        end else begin
            a_out     <= a_in;
            a_vld_out <= a_vld_in;
            b_out     <= b_in;
            b_vld_out <= b_vld_in;
        end
    end

    // Stage 1: accumulator, drain FSM and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACC;
            acc       <= '0;
            mac_cnt   <= '0;
            ovf       <= 1'b0;
            c_out     <= '0;
            c_vld_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    acc       <= acc_next;
                    ovf       <= ovf_next;
                    mac_cnt   <= cnt_next;
                    c_vld_out <= 1'b0;
                    busy      <= drain;
                    if (drain) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    c_out     <= acc;
                    c_vld_out <= 1'b1;
                    acc       <= '0;
                    mac_cnt   <= '0;
                    ovf       <= 1'b0;
                    busy      <= 1'b1;
                    state     <= ST_PASS;
                end
                ST_PASS: begin
                    // The exit cycle still shifts c_in but marks it invalid.
                    c_out     <= c_in;
                    c_vld_out <= drain & c_vld_in;
                    busy      <= drain;
                    if (!drain) begin
                        state <= ST_ACC;
                    end
                end
                default: begin
                    state <= ST_ACC;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_pe_acc.sv
module tb_systolic_pe_acc;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] a_in;
    logic              a_vld_in;
    logic [DATA_W-1:0] b_in;
    logic              b_vld_in;
    logic              clr;
    logic              drain;
    logic [ACC_W-1:0]  c_in;
    logic              c_vld_in;
    logic [DATA_W-1:0] a_out;
    logic              a_vld_out;
    logic [DATA_W-1:0] b_out;
    logic              b_vld_out;
    logic [ACC_W-1:0]  c_out;
    logic              c_vld_out;
    logic [CNT_W-1:0]  mac_cnt;
    logic              busy;
    logic              ovf;

    int n_chk  = 0;
    int n_fail = 0;

    systolic_pe_acc #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .SIGNED(1),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .a_vld_in (a_vld_in),
        .b_in     (b_in),
        .b_vld_in (b_vld_in),
        .clr      (clr),
        .drain    (drain),
        .c_in     (c_in),
        .c_vld_in (c_vld_in),
        .a_out    (a_out),
        .a_vld_out(a_vld_out),
        .b_out    (b_out),
        .b_vld_out(b_vld_out),
        .c_out    (c_out),
        .c_vld_out(c_vld_out),
        .mac_cnt  (mac_cnt),
        .busy     (busy),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mac(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic c);
        a_in = a; b_in = b; a_vld_in = 1'b1; b_vld_in = 1'b1; clr = c;
    endtask

    task automatic idle();
        a_vld_in = 1'b0; b_vld_in = 1'b0; clr = 1'b0; drain = 1'b0;
        c_vld_in = 1'b0;
    endtask

    initial begin
        // Reset dominates active inputs
        rst = 1'b1; a_in = 16'd5; b_in = 16'd9; a_vld_in = 1'b1; b_vld_in = 1'b1;
        clr = 1'b0; drain = 1'b1; c_in = 32'd77; c_vld_in = 1'b1;
        tick(); tick();
        chk("rst_a_out", a_out, 0);
        chk("rst_a_vld", a_vld_out, 0);
        chk("rst_b_out", b_out, 0);
        chk("rst_b_vld", b_vld_out, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_c_vld", c_vld_out, 0);
        chk("rst_cnt", mac_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0; idle(); c_in = '0;
        tick();

        // Tile: 3*4 + 5*(-2) + 7*1 = 9, one-cycle drain
        mac(16'd3, 16'd4, 1'b1); tick();
        chk("t1_cnt1", mac_cnt, 1);
        chk("t1_a_fwd", a_out, 3);
        chk("t1_b_fwd", b_out, 4);
        mac(16'd5, 16'hFFFE, 1'b0); tick();
        chk("t1_cnt2", mac_cnt, 2);
        chk("t1_b_neg_fwd", b_out, 16'hFFFE);
        mac(16'd7, 16'd1, 1'b0); tick();
        chk("t1_cnt3", mac_cnt, 3);
        idle(); drain = 1'b1; tick();
        chk("t1_busy_load", busy, 1);
        chk("t1_cnt_before_load", mac_cnt, 3);
        chk("t1_cvld_pre", c_vld_out, 0);
        drain = 1'b0; tick();
        chk("t1_c_out", c_out, 9);
        chk("t1_c_vld", c_vld_out, 1);
        chk("t1_cnt_after_load", mac_cnt, 0);
        chk("t1_busy_pass", busy, 1);
        tick();
        chk("t1_busy_exit", busy, 0);
        chk("t1_cvld_exit", c_vld_out, 0);

        // Drain in the same cycle as a 4th pair: 9 + 2*2 = 13
        mac(16'd3, 16'd4, 1'b1); tick();
        mac(16'd5, 16'hFFFE, 1'b0); tick();
        mac(16'd7, 16'd1, 1'b0); tick();
        mac(16'd2, 16'd2, 1'b0); drain = 1'b1; tick();
        chk("t2_cnt4", mac_cnt, 4);
        idle(); tick();
        chk("t2_c_out", c_out, 13);
        chk("t2_c_vld", c_vld_out, 1);
        tick();

        // Three-cycle drain with pass-through from the north
        mac(16'd9, 16'd9, 1'b1); tick();
        idle(); drain = 1'b1; tick();
        chk("t3_busy_c0", busy, 1);
        tick();
        chk("t3_c_acc", c_out, 81);
        chk("t3_vld_acc", c_vld_out, 1);
        chk("t3_busy_c1", busy, 1);
        c_in = 32'd100; c_vld_in = 1'b1; tick();
        chk("t3_c_100", c_out, 100);
        chk("t3_vld_100", c_vld_out, 1);
        chk("t3_busy_c2", busy, 1);
        drain = 1'b0; c_in = 32'd200; c_vld_in = 1'b0; tick();
        chk("t3_c_200", c_out, 200);
        chk("t3_vld_200", c_vld_out, 0);
        chk("t3_busy_c3", busy, 0);
        c_in = '0;

        // A valid without B: no accumulation, forwarding continues
        mac(16'd1, 16'd1, 1'b1); tick();
        chk("t5_cnt_seed", mac_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            a_in = DATA_W'(20 + i); a_vld_in = 1'b1; b_in = 16'd7; b_vld_in = 1'b0; clr = 1'b0;
            tick();
            chk("t5_a_out", a_out, 20 + i);
            chk("t5_b_vld", b_vld_out, 0);
            chk("t5_cnt", mac_cnt, 1);
        end
        idle(); drain = 1'b1; tick();
        drain = 1'b0; tick();
        chk("t5_acc", c_out, 1);
        tick();

        // Signed overflow: 3 * 0x3FFF0001 exceeds 0x7FFFFFFF
        mac(16'd32767, 16'd32767, 1'b1); tick();
        mac(16'd32767, 16'd32767, 1'b0); tick();
        chk("ovf_pre", ovf, 0);
        tick();
        chk("ovf_set", ovf, 1);
        chk("ovf_cnt", mac_cnt, 3);
        idle(); tick();
        chk("ovf_sticky", ovf, 1);
        drain = 1'b1; tick();
        drain = 1'b0; tick();
`ifdef SYSTOLIC_PE_SAT_EN
        chk("ovf_c_out", c_out, 32'h7FFF_FFFF);
`else
        chk("ovf_c_out", c_out, 32'hBFFD_0003);
`endif
        chk("ovf_cleared", ovf, 0);
        tick();

        // Reset in the middle of PASS
        mac(16'd2, 16'd3, 1'b1); tick();
        idle(); drain = 1'b1; tick();
        tick();
        chk("rp_c_pre", c_out, 6);
        chk("rp_busy_pre", busy, 1);
        c_in = 32'd55; c_vld_in = 1'b1; a_in = 16'd4; a_vld_in = 1'b1; rst = 1'b1;
        tick();
        chk("rp_c_out", c_out, 0);
        chk("rp_c_vld", c_vld_out, 0);
        chk("rp_busy", busy, 0);
        chk("rp_a_out", a_out, 0);
        chk("rp_a_vld", a_vld_out, 0);
        rst = 1'b0; idle(); c_in = '0;
        mac(16'd6, 16'd6, 1'b0); tick();
        chk("rp_cnt", mac_cnt, 1);
        idle(); drain = 1'b1; tick();
        chk("rp_busy_load", busy, 1);
        drain = 1'b0; tick();
        chk("rp_acc", c_out, 36);
        chk("rp_vld", c_vld_out, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
